// File: rtl/ping_scheduler.sv
// Ping scheduler: walks the slot table one ping per slot, driving the transmit
// pulse generator and opening a receive listen window after each burst.
module ping_scheduler #(
    parameter int N_SLOTS      = 4,
    parameter int HALF_PERIOD  = 9,
    parameter int SYNC_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cfg_we,
    input  logic [$clog2(N_SLOTS)-1:0] cfg_addr,
    input  logic [15:0]                cfg_pattern,
    input  logic [15:0]                cfg_mask,
    input  logic [15:0]                cfg_pulse_len,
    input  logic [31:0]                cfg_listen,
    input  logic [$clog2(N_SLOTS):0]   n_active,
    input  logic                       run,
    input  logic                       continuous,
    input  logic                       gen_frame_sync,
    output logic                       gen_enable,
    output logic [15:0]                gen_pattern,
    output logic [15:0]                gen_mask,
    output logic [15:0]                gen_pulse_len,
    output logic [31:0]                gen_tx_period,
    output logic [$clog2(N_SLOTS)-1:0] slot_idx,
    output logic                       rx_window,
    output logic                       ping_start,
    output logic                       sweep_done,
    output logic                       busy,
    output logic                       sync_err
);

    localparam int AW = $clog2(N_SLOTS);
    localparam int NW = AW + 1;
    localparam int SW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [31:0] BURST_PER_LEN = 32'(32 * HALF_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_WAIT_SYNC, S_TX, S_LISTEN, S_NEXT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0] r_tab_pat [N_SLOTS];
    logic [15:0] r_tab_msk [N_SLOTS];
    logic [15:0] r_tab_pl  [N_SLOTS];
    logic [31:0] r_tab_lis [N_SLOTS];

    logic [AW-1:0] r_slot_idx;
    logic [15:0]   r_gen_pattern;
    logic [15:0]   r_gen_mask;
    logic [15:0]   r_gen_pulse_len;
    logic [31:0]   r_burst;
    logic [31:0]   r_listen;
    logic [31:0]   r_cnt;
    logic [SW-1:0] r_sync_cnt;
    logic          r_sync_err;
    logic          r_ping_start;

    logic [15:0]   w_rd_pl;
    logic [15:0]   w_pl_eff;
    logic [NW-1:0] w_n_eff;
    logic          w_last;
    logic          w_start;
    logic          w_sync_expired;

    // Slot table: writable at any time, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_tab_pat[i] <= '0;
                r_tab_msk[i] <= '0;
                r_tab_pl[i]  <= '0;
                r_tab_lis[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tab_pat[cfg_addr] <= cfg_pattern;
            r_tab_msk[cfg_addr] <= cfg_mask;
            r_tab_pl[cfg_addr]  <= cfg_pulse_len;
            r_tab_lis[cfg_addr] <= cfg_listen;
        end
    end

    assign w_rd_pl  = r_tab_pl[r_slot_idx];
    assign w_pl_eff = (w_rd_pl == 16'd0) ? 16'd1 : w_rd_pl;
    assign w_n_eff  = (n_active > NW'(N_SLOTS)) ? NW'(N_SLOTS) : n_active;
    // ">=" rather than "==" so a shrunk n_active mid-sweep still wraps cleanly.
    assign w_last   = ({1'b0, r_slot_idx} + NW'(1)) >= w_n_eff;
    assign w_start  = run && (n_active != '0) && !r_sync_err;
    assign w_sync_expired = r_sync_cnt >= SW'(SYNC_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_state_next = S_ARM;
            S_ARM:       w_state_next = S_WAIT_SYNC;
            S_WAIT_SYNC: begin
                if (gen_frame_sync)      w_state_next = S_TX;
                else if (w_sync_expired) w_state_next = S_IDLE;
            end
            S_TX:        if (r_cnt == 32'd0) w_state_next = S_LISTEN;
            S_LISTEN:    if (r_cnt <= 32'd1) w_state_next = S_NEXT;
            S_NEXT: begin
                if (w_last) w_state_next = (continuous && run) ? S_ARM : S_IDLE;
                else        w_state_next = run ? S_ARM : S_IDLE;
            end
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        gen_enable = (r_state == S_WAIT_SYNC) || (r_state == S_TX);
        rx_window  = (r_state == S_LISTEN) && (r_cnt != 32'd0);
        sweep_done = (r_state == S_NEXT) && w_last;
        busy       = (r_state != S_IDLE);
    end

    // Datapath. TX counter is loaded with burst-1 so the burst lasts exactly
    // burst_cycles; listen counts down to 1 so rx_window spans cfg_listen cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_slot_idx      <= '0;
            r_gen_pattern   <= '0;
            r_gen_mask      <= '0;
            r_gen_pulse_len <= '0;
            r_burst         <= '0;
            r_listen        <= '0;
            r_cnt           <= '0;
            r_sync_cnt      <= '0;
            r_sync_err      <= 1'b0;
            r_ping_start    <= 1'b0;
        end else begin
            r_ping_start <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) r_slot_idx <= '0;
                S_ARM: begin
                    r_gen_pattern   <= r_tab_pat[r_slot_idx];
                    r_gen_mask      <= r_tab_msk[r_slot_idx];
                    r_gen_pulse_len <= w_rd_pl;
                    r_listen        <= r_tab_lis[r_slot_idx];
                    r_burst         <= 32'(w_pl_eff) * BURST_PER_LEN;
                    r_sync_cnt      <= '0;
                end
                S_WAIT_SYNC: begin
                    if (gen_frame_sync) begin
                        r_ping_start <= 1'b1;
                        r_cnt        <= r_burst - 32'd1;
                    end else if (w_sync_expired) begin
                        r_sync_err <= 1'b1;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + SW'(1);
                    end
                end
                S_TX: begin
                    if (r_cnt == 32'd0) r_cnt <= r_listen;
                    else                r_cnt <= r_cnt - 32'd1;
                end
                S_LISTEN: if (r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
                S_NEXT:   r_slot_idx <= w_last ? '0 : r_slot_idx + AW'(1);
                default: ;
            endcase
        end
    end

    assign gen_pattern   = r_gen_pattern;
    assign gen_mask      = r_gen_mask;
    assign gen_pulse_len = r_gen_pulse_len;
    assign gen_tx_period = 32'hFFFF_FFFE;
    assign slot_idx      = r_slot_idx;
    assign ping_start    = r_ping_start;
    assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_ping_scheduler.sv
// Scoreboard bench for ping_scheduler: stimulus pushes expected pings derived
// from a shadow slot table; a negedge monitor pops and measures each ping.
`timescale 1ns/1ps
module tb_ping_scheduler;
    localparam int N_SLOTS      = 4;
    localparam int HALF_PERIOD  = 9;
    localparam int SYNC_TIMEOUT = 4;
    localparam int AW = $clog2(N_SLOTS);
    localparam int NW = AW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [15:0]   cfg_pattern = '0, cfg_mask = '0, cfg_pulse_len = '0;
    logic [31:0]   cfg_listen = '0;
    logic [NW-1:0] n_active = '0;
    logic          run = 1'b0, continuous = 1'b0, gen_frame_sync = 1'b0;
    logic          gen_enable, rx_window, ping_start, sweep_done, busy, sync_err;
    logic [15:0]   gen_pattern, gen_mask, gen_pulse_len;
    logic [31:0]   gen_tx_period;
    logic [AW-1:0] slot_idx;

    ping_scheduler #(.N_SLOTS(N_SLOTS), .HALF_PERIOD(HALF_PERIOD), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_pulse_len(cfg_pulse_len),
        .cfg_listen(cfg_listen), .n_active(n_active), .run(run), .continuous(continuous),
        .gen_frame_sync(gen_frame_sync), .gen_enable(gen_enable), .gen_pattern(gen_pattern),
        .gen_mask(gen_mask), .gen_pulse_len(gen_pulse_len), .gen_tx_period(gen_tx_period),
        .slot_idx(slot_idx), .rx_window(rx_window), .ping_start(ping_start),
        .sweep_done(sweep_done), .busy(busy), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          slot;
        logic [15:0] pat;
        logic [15:0] msk;
        logic [15:0] pl;
        int          tx;
        int          lis;
        bit          sweep;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pings_seen = 0;
    logic [15:0] sh_pat [N_SLOTS];
    logic [15:0] sh_msk [N_SLOTS];
    logic [15:0] sh_pl  [N_SLOTS];
    int          sh_lis [N_SLOTS];
    bit          tie_low = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int n_eff(input int n);
        return (n > N_SLOTS) ? N_SLOTS : n;
    endfunction

    // Reference: burst = 32 carrier half-periods per pulse-length unit, pulse_len 0 acts as 1.
    function automatic void push_ping(input int s, input bit sw);
        exp_t e;
        e.slot  = s;
        e.pat   = sh_pat[s];
        e.msk   = sh_msk[s];
        e.pl    = sh_pl[s];
        e.tx    = 32 * HALF_PERIOD * ((sh_pl[s] == 16'd0) ? 1 : int'(sh_pl[s]));
        e.lis   = sh_lis[s];
        e.sweep = sw;
        exp_q.push_back(e);
    endfunction

    function automatic void push_sweep(input int n);
        for (int s = 0; s < n_eff(n); s++) push_ping(s, s == n_eff(n) - 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input int a, input logic [15:0] p, input logic [15:0] m,
                             input logic [15:0] pl, input logic [31:0] l);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_pattern = p; cfg_mask = m;
        cfg_pulse_len = pl; cfg_listen = l;
        tick(1);
        cfg_we = 1'b0;
        sh_pat[a] = p; sh_msk[a] = m; sh_pl[a] = pl; sh_lis[a] = int'(l);
    endtask

    task automatic wait_pings(input int target, input int budget, input string name);
        int k = 0;
        while (pings_seen < target && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (pings_seen < target) begin
            failures++;
            $display("FAIL %s: timed out with pings=%0d required=%0d", name, pings_seen, target);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(name, busy, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_gen_enable"}, gen_enable, 0);
        chk({tag, "_gen_pattern"}, gen_pattern, 0);
        chk({tag, "_gen_mask"}, gen_mask, 0);
        chk({tag, "_gen_pulse_len"}, gen_pulse_len, 0);
        chk({tag, "_gen_tx_period"}, gen_tx_period, 32'hFFFF_FFFE);
        chk({tag, "_slot_idx"}, slot_idx, 0);
        chk({tag, "_rx_window"}, rx_window, 0);
        chk({tag, "_ping_start"}, ping_start, 0);
        chk({tag, "_sweep_done"}, sweep_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
    endtask

    task automatic run_sweep(input int n, input string tag);
        int base;
        push_sweep(n);
        n_active = NW'(n);
        continuous = 1'b0;
        base = pings_seen;
        run = 1'b1;
        wait_pings(base + n_eff(n), n_eff(n) * 1500 + 100, {tag, "_pings"});
        run = 1'b0;
        wait_idle(3000, {tag, "_idle"});
        chk({tag, "_slot_idx_after"}, slot_idx, 0);
    endtask

    // Generator model: answers each gen_enable rise with a frame_sync 0..SYNC_TIMEOUT-1
    // cycles later, plus stray syncs when they must be ignored.
    int fs_pend = -1;
    bit fs_synced = 1'b0;
    bit ge_prev = 1'b0;
    initial begin : frame_sync_driver
        forever begin
            @(negedge clk);
            if (tie_low || !rstn) begin
                gen_frame_sync = 1'b0; fs_pend = -1; fs_synced = 1'b0;
            end else if (!gen_enable) begin
                fs_pend = -1; fs_synced = 1'b0;
                gen_frame_sync = ($urandom_range(0, 7) == 0);
            end else begin
                if (!ge_prev) begin
                    fs_pend = $urandom_range(0, SYNC_TIMEOUT - 1);
                    fs_synced = 1'b0;
                end
                if (fs_synced) begin
                    gen_frame_sync = ($urandom_range(0, 3) == 0);
                end else if (fs_pend == 0) begin
                    gen_frame_sync = 1'b1; fs_synced = 1'b1; fs_pend = -1;
                end else begin
                    gen_frame_sync = 1'b0; fs_pend--;
                end
            end
            ge_prev = gen_enable && rstn;
        end
    end

    bit   mon_in_ping = 1'b0;
    bit   mon_tx_done = 1'b0;
    int   mon_tx = 0, mon_rx = 0, mon_sd = 0, mon_post = 0;
    exp_t mon_cur;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_in_ping = 1'b0;
            end else begin
                if (!mon_in_ping) begin
                    chk("stray_sweep_done", sweep_done, 0);
                    chk("stray_rx_window", rx_window, 0);
                end else begin
                    if (!mon_tx_done) begin
                        if (gen_enable) mon_tx++;
                        else begin
                            mon_tx_done = 1'b1;
                            mon_post = 0;
                            chk("tx_cycles", mon_tx, mon_cur.tx);
                        end
                    end else begin
                        mon_post++;
                    end
                    if (mon_tx_done) begin
                        if (rx_window) mon_rx++;
                        if (sweep_done) begin
                            mon_sd++;
                            chk("sweep_done_position", mon_post, (mon_cur.lis == 0) ? 1 : mon_cur.lis);
                        end
                        if (gen_enable || !busy) begin
                            chk("rx_cycles", mon_rx, mon_cur.lis);
                            chk("sweep_done_count", mon_sd, mon_cur.sweep ? 1 : 0);
                            mon_in_ping = 1'b0;
                        end
                    end
                end
                if (ping_start) begin
                    pings_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ping: slot_idx=%0d with no ping expected", slot_idx);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        $display("ping %0d: slot=%0d pattern=%h mask=%h pulse_len=%0d", pings_seen,
                                 slot_idx, gen_pattern, gen_mask, gen_pulse_len);
                        chk("ping_slot_idx", slot_idx, mon_cur.slot);
                        chk("ping_gen_pattern", gen_pattern, mon_cur.pat);
                        chk("ping_gen_mask", gen_mask, mon_cur.msk);
                        chk("ping_gen_pulse_len", gen_pulse_len, mon_cur.pl);
                        chk("ping_gen_tx_period", gen_tx_period, 32'hFFFF_FFFE);
                        chk("ping_gen_enable", gen_enable, 1);
                        mon_in_ping = 1'b1; mon_tx_done = 1'b0;
                        mon_tx = 1; mon_rx = 0; mon_sd = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base, k, seen;
        for (int i = 0; i < N_SLOTS; i++) begin
            sh_pat[i] = '0; sh_msk[i] = '0; sh_pl[i] = '0; sh_lis[i] = 0;
        end
        tick(3);
        rstn = 1'b1;
        tick(1);
        check_reset("reset");

        // Basic single ping: 2 * 288 burst cycles, 1000 listen cycles.
        cfg_write(0, 16'hA5A5, 16'hFFFF, 16'd2, 32'd1000);
        run_sweep(1, "single_ping");
        tick(5);
        chk("single_ping_stays_idle", busy, 0);

        // pulse_len 0 acts as 1; listen 0 passes straight through.
        cfg_write(0, 16'($urandom), 16'($urandom), 16'd0, 32'd0);
        run_sweep(1, "len0_listen0");

        // Continuous sweep over 3 slots with a slot-0 rewrite during its TX.
        for (int s = 0; s < 3; s++)
            cfg_write(s, {8'(s + 1), 8'($urandom)}, 16'($urandom),
                      16'($urandom_range(1, 3)), 32'($urandom_range(0, 60)));
        n_active = NW'(3);
        continuous = 1'b1;
        base = pings_seen;
        push_ping(0, 1'b0);
        run = 1'b1;
        wait_pings(base + 1, 100, "cont_first_ping");
        cfg_write(0, 16'h1234, sh_msk[0], sh_pl[0], 32'(sh_lis[0]));
        for (int p = 1; p < 8; p++) push_ping(p % 3, (p % 3) == 2);
        wait_pings(base + 8, 8 * 1500, "cont_pings");
        run = 1'b0;
        wait_idle(3000, "cont_idle");
        chk("cont_stop_slot_idx", slot_idx, 2);
        continuous = 1'b0;

        // n_active 0 never starts.
        n_active = '0;
        run = 1'b1;
        seen = 0;
        repeat (20) begin
            tick(1);
            if (busy || gen_enable) seen++;
        end
        chk("n_active0_no_start", seen, 0);
        run = 1'b0;
        tick(2);

        // Randomized single sweeps, including n_active above N_SLOTS.
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < N_SLOTS; s++)
                cfg_write(s, 16'($urandom), 16'($urandom), 16'($urandom_range(0, 2)),
                          ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 80)));
            run_sweep($urandom_range(1, 7), $sformatf("rand%0d", r));
        end

        // Reset in the middle of a listen window.
        cfg_write(0, 16'($urandom), 16'($urandom), 16'd1, 32'd1000);
        push_sweep(1);
        n_active = NW'(1);
        base = pings_seen;
        run = 1'b1;
        wait_pings(base + 1, 100, "rst_ping");
        k = 0;
        while (rx_window !== 1'b1 && k < 1000) begin
            tick(1);
            k++;
        end
        chk("rst_reached_listen", rx_window, 1);
        tick(10);
        run = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_mid_listen");
        exp_q.delete();
        tick(1);
        rstn = 1'b1;
        for (int i = 0; i < N_SLOTS; i++) begin
            sh_pat[i] = '0; sh_msk[i] = '0; sh_pl[i] = '0; sh_lis[i] = 0;
        end
        run_sweep(1, "after_reset_table");

        // Frame sync never arrives: timeout, sticky error, run ignored.
        tie_low = 1'b1;
        n_active = NW'(1);
        run = 1'b1;
        k = 0;
        while (gen_enable !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        chk("sync_enable_rise", gen_enable, 1);
        k = 0;
        while (gen_enable === 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        chk("sync_timeout_cycles", k, SYNC_TIMEOUT);
        chk("sync_err_set", sync_err, 1);
        chk("sync_err_idle", busy, 0);
        seen = 0;
        repeat (30) begin
            tick(1);
            if (busy || gen_enable) seen++;
        end
        chk("sync_err_blocks_run", seen, 0);
        chk("sync_err_sticky", sync_err, 1);
        run = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tie_low = 1'b0;
        tick(1);
        chk("sync_err_cleared_by_reset", sync_err, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ping_scheduler.md
Name: ping_scheduler

Overview:
- Sequences the ultrasound transmit pulse generator through a small table of ping configurations (slots), one ping per slot.
- Per ping: configures the generator, enables it, confirms frame start, times the burst, then opens a receive listen window before advancing to the next slot.
- Sits between the register/control interface and the pulse generator; the rx_window output gates the echo capture path.

Parameters:
- N_SLOTS, 4, number of configuration slots (power of 2, 2..16).
- HALF_PERIOD, 9, generator carrier half-period in clk cycles; must match the generator instance.
- SYNC_TIMEOUT, 4, max cycles from gen_enable rise to gen_frame_sync before error.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- cfg_we  in  1  slot table write strobe
- cfg_addr  in  $clog2(N_SLOTS)  slot index written
- cfg_pattern  in  16  slot pattern
- cfg_mask  in  16  slot mask
- cfg_pulse_len  in  16  carrier periods per bit; 0 illegal, treated as 1
- cfg_listen  in  32  listen window length in cycles
- n_active  in  $clog2(N_SLOTS)+1  slots used per sweep (0 = none)
- run  in  1  level; start/continue sequencing
- continuous  in  1  1 = repeat sweeps, 0 = single sweep
- gen_frame_sync  in  1  frame start pulse from generator
- gen_enable  out  1  generator enable
- gen_pattern / gen_mask / gen_pulse_len  out  16 each  active slot config
- gen_tx_period  out  32  held at 32'hFFFF_FFFE (no auto-repeat inside a ping)
- slot_idx  out  $clog2(N_SLOTS)  active slot
- rx_window  out  1  high during listen
- ping_start  out  1  1-cycle pulse on accepted frame_sync
- sweep_done  out  1  1-cycle pulse after last slot's listen ends
- busy  out  1  state != IDLE
- sync_err  out  1  sticky; set on frame_sync timeout; cleared only by reset

Behaviour:
- Reset: state IDLE; all outputs 0 except gen_tx_period = 32'hFFFF_FFFE; slot table cleared to 0; slot_idx 0.
- Table writes are accepted in any state. The active slot's config is latched into gen_* on entry to ARM, so writes to the active slot take effect on its next visit.
- IDLE: if run && n_active != 0 && !sync_err, go to ARM with slot_idx = 0.
- ARM: 1 cycle.
  - Latch slot config into gen_*.
  - Compute burst_cycles = 32 * HALF_PERIOD * max(pulse_len, 1) into a 32-bit register (no overflow for 16-bit pulse_len).
  - Go to WAIT_SYNC.
- WAIT_SYNC:
  - gen_enable = 1; count cycles.
  - On gen_frame_sync: pulse ping_start, go to TX, load down-counter with burst_cycles.
  - If count reaches SYNC_TIMEOUT with no sync: set sync_err, gen_enable = 0, go to IDLE.
- TX:
  - gen_enable stays 1; decrement each cycle.
  - At 0: gen_enable = 0; go to LISTEN, loaded with cfg_listen of the active slot (latched at ARM).
- LISTEN:
  - rx_window = 1 while counter > 0.
  - cfg_listen = 0 gives zero listen cycles: pass straight through LISTEN in 1 cycle with rx_window held low.
  - On expiry go to NEXT.
- NEXT: 1 cycle.
  - If slot_idx == n_active-1, pulse sweep_done and set slot_idx = 0:
    - continuous && run → ARM
    - else → IDLE
  - Otherwise slot_idx++; run → ARM, !run → IDLE.
- run deassert mid-ping: the current ping and its listen window complete; stop at NEXT. There is no abort except reset.
- n_active > N_SLOTS is clamped to N_SLOTS. n_active is sampled in NEXT.
- Reset mid-operation: immediate return to reset values, including gen_enable = 0 the next cycle.
- gen_frame_sync outside WAIT_SYNC is ignored.

Test Plan:
- Slot0 {pattern 0xA5A5, mask 0xFFFF, pulse_len 2, listen 1000}, n_active 1, continuous 0, run 1 → gen_enable high for exactly 576 cycles after sync; then rx_window high 1000 cycles; one sweep_done pulse; back in IDLE, busy 0.
- Slots 0..2 with distinct patterns, n_active 3, continuous 1:
  - gen_pattern follows slot 0,1,2,0,… and sweep_done pulses every third ping.
  - Drop run during slot1 TX → slot1 listen completes, then IDLE with slot_idx 2.
- Tie gen_frame_sync low → sync_err set 4 cycles after gen_enable rise; gen_enable drops; further run ignored until reset.
- Write slot0 pattern 0x1234 during slot0 TX → gen_pattern unchanged for the current ping; 0x1234 appears on the next slot0 ARM.
- cfg_pulse_len 0 → burst 288 cycles (HALF_PERIOD 9).
- cfg_listen 0 → rx_window never asserts; NEXT follows TX within 2 cycles.
- Assert rstn low mid-LISTEN → next cycle all outputs at reset values; table reads back 0 on the next sweep.
